expr_sequencer: RTL and testbench

- Control FSM for the expression-solver datapath.
- Computes Y = ((in1 + in2) - in3) + in4 by stepping the 4:1 operand mux select, the ALU opcode and the accumulator load/clear strobes.
- Uses a start/done/ack handshake toward the host.
- Sits beside the operand mux, the ALU and the accumulator register.
- Supports multi-cycle ALUs by holding each step for ALU_LAT cycles.

---
 rtl/expr_pkg.sv | 44 ++++
 rtl/step_timer.sv | 40 ++++
 rtl/expr_sequencer.sv | 117 +++++++++++
 tb/tb_expr_sequencer.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/expr_pkg.sv
// Shared types and decode helpers for the expression-solver sequencer.
package expr_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_ADD2 = 3'd2,
    ST_SUB3 = 3'd3,
    ST_ADD4 = 3'd4,
    ST_DONE = 3'd5
  } state_e;

  localparam logic [1:0] OP_PASS = 2'b00;
  localparam logic [1:0] OP_ADD  = 2'b01;
  localparam logic [1:0] OP_SUB  = 2'b10;

  localparam logic [1:0] SEL_IN1 = 2'b00;
  localparam logic [1:0] SEL_IN2 = 2'b01;
  localparam logic [1:0] SEL_IN3 = 2'b10;
  localparam logic [1:0] SEL_IN4 = 2'b11;

  function automatic logic is_step(input state_e s);
    return (s == ST_LOAD) || (s == ST_ADD2) || (s == ST_SUB3) || (s == ST_ADD4);
  endfunction

  function automatic logic [1:0] step_sel(input state_e s);
    case (s)
      ST_ADD2: return SEL_IN2;
      ST_SUB3: return SEL_IN3;
      ST_ADD4: return SEL_IN4;
      default: return SEL_IN1;
    endcase
  endfunction

  function automatic logic [1:0] step_op(input state_e s);
    case (s)
      ST_ADD2: return OP_ADD;
      ST_SUB3: return OP_SUB;
      ST_ADD4: return OP_ADD;
      default: return OP_PASS;
    endcase
  endfunction

endpackage

// File: rtl/step_timer.sv
// Step-hold counter: counts cycles spent in one datapath step and flags the last one.
module step_timer #(
  parameter int ALU_LAT = 1,
  parameter int CNT_W   = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic last,
  output logic last_nxt
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ALU_LAT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // last_nxt lets the owner register strobes that line up with the next count.
  assign last     = (cnt_q == LAST_CNT);
  assign last_nxt = (cnt_d == LAST_CNT);

endmodule

// File: rtl/expr_sequencer.sv
// Control FSM computing Y = ((in1 + in2) - in3) + in4 over the mux/ALU/accumulator.
// Optional step freeze input enabled by EXPR_SEQUENCER_PAUSE_EN.
module expr_sequencer
  import expr_pkg::*;
#(
  parameter int ALU_LAT = 1,
  parameter int CNT_W   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       ack,
`ifdef EXPR_SEQUENCER_PAUSE_EN
  input  logic       pause,
`endif
  output logic [1:0] M,
  output logic [1:0] alu_op,
  output logic       acc_clr,
  output logic       acc_ld,
  output logic       busy,
  output logic       done
);

  state_e     state_q, state_d;
  logic       tmr_clr, tmr_en, last, last_nxt, hold;
  logic [1:0] m_q, m_d, alu_op_q, alu_op_d;
  logic       acc_clr_q, acc_clr_d, acc_ld_q, acc_ld_d;
  logic       busy_q, busy_d, done_q, done_d;

`ifdef EXPR_SEQUENCER_PAUSE_EN
  assign hold = pause && is_step(state_q);
`else
  assign hold = 1'b0;
`endif

  step_timer #(.ALU_LAT(ALU_LAT), .CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clr      (tmr_clr),
    .en       (tmr_en),
    .last     (last),
    .last_nxt (last_nxt)
  );

  always_comb begin
    state_d = state_q;
    tmr_clr = 1'b0;
    tmr_en  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        tmr_clr = 1'b1;
        if (start) state_d = ST_LOAD;
      end
      ST_LOAD, ST_ADD2, ST_SUB3, ST_ADD4: begin
        if (!hold) begin
          if (last) begin
            tmr_clr = 1'b1;
            case (state_q)
              ST_LOAD: state_d = ST_ADD2;
              ST_ADD2: state_d = ST_SUB3;
              ST_SUB3: state_d = ST_ADD4;
              default: state_d = ST_DONE;
            endcase
          end else begin
            tmr_en = 1'b1;
          end
        end
      end
      ST_DONE: begin
        tmr_clr = 1'b1;
        if (ack) state_d = start ? ST_LOAD : ST_IDLE;
      end
      default: begin
        tmr_clr = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs are decoded from the upcoming state/count so every port comes straight off a flop.
  always_comb begin
    m_d       = step_sel(state_d);
    alu_op_d  = step_op(state_d);
    busy_d    = is_step(state_d);
    done_d    = (state_d == ST_DONE);
    acc_ld_d  = is_step(state_d) && last_nxt && !hold;
    acc_clr_d = (state_d == ST_LOAD) && (state_q != ST_LOAD);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      m_q       <= SEL_IN1;
      alu_op_q  <= OP_PASS;
      acc_clr_q <= 1'b0;
      acc_ld_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      m_q       <= m_d;
      alu_op_q  <= alu_op_d;
      acc_clr_q <= acc_clr_d;
      acc_ld_q  <= acc_ld_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign M       = m_q;
  assign alu_op  = alu_op_q;
  assign acc_clr = acc_clr_q;
  assign acc_ld  = acc_ld_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_expr_sequencer.sv
// Bench for expr_sequencer: one instance with ALU_LAT=1 and one with ALU_LAT=3,
// both checked cycle by cycle against an evaluation-timeline reference model.
module tb_expr_sequencer;

  logic       clk = 1'b0;
  logic       rst_s   [2];
  logic       start_s [2];
  logic       ack_s   [2];
`ifdef EXPR_SEQUENCER_PAUSE_EN
  logic       pause_s [2];
`endif
  logic [1:0] m_o     [2];
  logic [1:0] op_o    [2];
  logic       clr_o   [2];
  logic       ld_o    [2];
  logic       busy_o  [2];
  logic       done_o  [2];

  int checks = 0;
  int passes = 0;

  // reference model: phase 0 idle, 1 running at cycle t of the evaluation, 2 done
  int   ph  [2];
  int   t   [2];
  logic rep [2];

  always #5 clk = ~clk;

  expr_sequencer #(.ALU_LAT(1), .CNT_W(4)) u_dut1 (
    .clk(clk), .rst(rst_s[0]), .start(start_s[0]), .ack(ack_s[0]),
`ifdef EXPR_SEQUENCER_PAUSE_EN
    .pause(pause_s[0]),
`endif
    .M(m_o[0]), .alu_op(op_o[0]), .acc_clr(clr_o[0]), .acc_ld(ld_o[0]),
    .busy(busy_o[0]), .done(done_o[0])
  );

  expr_sequencer #(.ALU_LAT(3), .CNT_W(4)) u_dut3 (
    .clk(clk), .rst(rst_s[1]), .start(start_s[1]), .ack(ack_s[1]),
`ifdef EXPR_SEQUENCER_PAUSE_EN
    .pause(pause_s[1]),
`endif
    .M(m_o[1]), .alu_op(op_o[1]), .acc_clr(clr_o[1]), .acc_ld(ld_o[1]),
    .busy(busy_o[1]), .done(done_o[1])
  );

  function automatic int lat(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  // packed as {M, alu_op, acc_clr, acc_ld, busy, done}
  function automatic logic [7:0] get_obs(input int i);
    return {m_o[i], op_o[i], clr_o[i], ld_o[i], busy_o[i], done_o[i]};
  endfunction

  function automatic logic [7:0] expect_out(input int i);
    int L;
    int stp;
    logic [1:0] op;
    L = lat(i);
    if (ph[i] == 0) return 8'h00;
    if (ph[i] == 2) return 8'h01;
    stp = (t[i] - 1) / L;
    op  = (stp == 0) ? 2'b00 : (stp == 2) ? 2'b10 : 2'b01;
    return {2'(stp), op, (t[i] == 1) && !rep[i], ((t[i] - 1) % L == L - 1) && !rep[i], 1'b1, 1'b0};
  endfunction

  task automatic model_step(input int i);
    logic p;
    p = 1'b0;
`ifdef EXPR_SEQUENCER_PAUSE_EN
    p = pause_s[i];
`endif
    rep[i] = 1'b0;
    if (rst_s[i]) begin
      ph[i] = 0;
    end else begin
      case (ph[i])
        0: if (start_s[i]) begin ph[i] = 1; t[i] = 1; end
        1: begin
          if (p) rep[i] = 1'b1;
          else if (t[i] == 4 * lat(i)) ph[i] = 2;
          else t[i] = t[i] + 1;
        end
        default: if (ack_s[i]) begin
          if (start_s[i]) begin ph[i] = 1; t[i] = 1; end
          else ph[i] = 0;
        end
      endcase
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
  endtask

  task automatic test_reset();
    logic [7:0] obs;
    for (int i = 0; i < 2; i++) begin
      obs = get_obs(i);
      checks++;
      if (obs !== 8'h00) $display("FAIL reset dut%0d: got %b want %b", i, obs, 8'h00);
      else passes++;
    end
    @(negedge clk);
    rst_s[0] = 1'b0;
    rst_s[1] = 1'b0;
  endtask

  // One evaluation from a start pulse; optionally hammers start/ack while busy.
  task automatic run_eval(input int i, input bit noise, input string tag);
    int L, lds, first;
    logic [7:0] obs, exp;
    L = lat(i);
    lds = 0;
    first = -1;
    start_s[i] = 1'b1;
    tick();
    start_s[i] = 1'b0;
    for (int k = 1; k <= 4 * L + 2; k++) begin
      if (k > 1) tick();
      obs = get_obs(i);
      exp = expect_out(i);
      checks++;
      if (obs !== exp) $display("FAIL %s dut%0d cyc %0d: got %b want %b", tag, i, k, obs, exp);
      else passes++;
      if (obs[2]) lds++;
      if (obs[0] && first < 0) first = k;
      if (noise && k <= 4 * L) begin
        start_s[i] = 1'($urandom_range(0, 1));
        ack_s[i]   = 1'($urandom_range(0, 1));
      end else begin
        start_s[i] = 1'b0;
        ack_s[i]   = 1'b0;
      end
    end
    checks++;
    if (lds != 4) $display("FAIL %s_ldcount dut%0d: got %0d want 4", tag, i, lds);
    else passes++;
    checks++;
    if (first != 4 * L + 1) $display("FAIL %s_donecyc dut%0d: got %0d want %0d", tag, i, first, 4 * L + 1);
    else passes++;
  endtask

  task automatic finish_ack(input int i);
    logic [7:0] obs, exp;
    int w;
    w = $urandom_range(0, 3);
    for (int k = 0; k < w + 3; k++) begin
      ack_s[i] = (k == w);
      tick();
      obs = get_obs(i);
      exp = expect_out(i);
      checks++;
      if (obs !== exp) $display("FAIL ack dut%0d step %0d: got %b want %b", i, k, obs, exp);
      else passes++;
    end
    ack_s[i] = 1'b0;
  endtask

  task automatic test_latency(input int i);
    run_eval(i, 1'b0, "latency");
    finish_ack(i);
  endtask

  task automatic test_ignored_inputs(input int i);
    run_eval(i, 1'b1, "ignored");
    finish_ack(i);
  endtask

  task automatic test_back_to_back(input int i);
    logic [7:0] obs, exp;
    run_eval(i, 1'b0, "b2b_first");
    start_s[i] = 1'b1;
    ack_s[i]   = 1'b1;
    tick();
    start_s[i] = 1'b0;
    ack_s[i]   = 1'b0;
    obs = get_obs(i);
    checks++;
    if (obs[3] !== 1'b1 || obs[1] !== 1'b1) $display("FAIL b2b_clr dut%0d: got %b want clr=1 busy=1", i, obs);
    else passes++;
    for (int k = 1; k <= 4 * lat(i) + 1; k++) begin
      if (k > 1) tick();
      obs = get_obs(i);
      exp = expect_out(i);
      checks++;
      if (obs !== exp) $display("FAIL b2b dut%0d cyc %0d: got %b want %b", i, k, obs, exp);
      else passes++;
    end
    finish_ack(i);
  endtask

  task automatic test_reset_mid(input int i);
    logic [7:0] obs, exp;
    int budget;
    start_s[i] = 1'b1;
    tick();
    start_s[i] = 1'b0;
    budget = 0;
    while (t[i] < 2 * lat(i) + 1 + (lat(i) > 1 ? 1 : 0) && budget < 50) begin
      tick();
      budget++;
    end
    checks++;
    if (op_o[i] !== 2'b10) $display("FAIL rstmid_reach dut%0d: got op %b want 10", i, op_o[i]);
    else passes++;
    #2 rst_s[i] = 1'b1;
    #1;
    ph[i] = 0;
    obs = get_obs(i);
    checks++;
    if (obs !== 8'h00) $display("FAIL rstmid_async dut%0d: got %b want %b", i, obs, 8'h00);
    else passes++;
    #1 rst_s[i] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      obs = get_obs(i);
      exp = expect_out(i);
      checks++;
      if (obs !== exp) $display("FAIL rstmid_idle dut%0d step %0d: got %b want %b", i, k, obs, exp);
      else passes++;
    end
    run_eval(i, 1'b0, "after_rst");
    finish_ack(i);
  endtask

  task automatic test_random(input int i);
    logic [7:0] obs, exp;
    for (int k = 0; k < 80; k++) begin
      start_s[i] = ($urandom_range(0, 2) == 0);
      ack_s[i]   = ($urandom_range(0, 2) == 0);
      tick();
      obs = get_obs(i);
      exp = expect_out(i);
      checks++;
      if (obs !== exp) $display("FAIL random dut%0d cyc %0d: got %b want %b", i, k, obs, exp);
      else passes++;
    end
    start_s[i] = 1'b0;
    ack_s[i]   = 1'b1;
    tick();
    ack_s[i]   = 1'b0;
    tick();
  endtask

`ifdef EXPR_SEQUENCER_PAUSE_EN
  task automatic test_pause();
    logic [7:0] obs, exp;
    int first, lds;
    first = -1;
    lds = 0;
    start_s[0] = 1'b1;
    tick();
    start_s[0] = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      if (k > 1) tick();
      obs = get_obs(0);
      exp = expect_out(0);
      checks++;
      if (obs !== exp) $display("FAIL pause cyc %0d: got %b want %b", k, obs, exp);
      else passes++;
      if (obs[0] && first < 0) first = k;
      if (obs[2] && obs[7:6] == 2'b01) lds++;
      pause_s[0] = (k == 2 || k == 3);
    end
    checks++;
    if (first != 7 || lds != 1) $display("FAIL pause_timing: got done %0d ld %0d want done 7 ld 1", first, lds);
    else passes++;
    finish_ack(0);
  endtask
`endif

  initial begin
    for (int i = 0; i < 2; i++) begin
      rst_s[i] = 1'b1;
      start_s[i] = 1'b0;
      ack_s[i] = 1'b0;
`ifdef EXPR_SEQUENCER_PAUSE_EN
      pause_s[i] = 1'b0;
`endif
      ph[i] = 0;
      t[i] = 0;
      rep[i] = 1'b0;
    end
    #3;
    test_reset();
    for (int i = 0; i < 2; i++) begin
      test_latency(i);
      test_ignored_inputs(i);
      test_back_to_back(i);
      test_reset_mid(i);
      test_random(i);
    end
`ifdef EXPR_SEQUENCER_PAUSE_EN
    test_pause();
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
